// File: rtl/ram_copy_dma_16_8_if.sv
// Bundle of control, status and RAM-port signals between the copy engine and its environment.
// start is a level request with no ready: it is honoured only while the engine is idle; busy/done report progress.
interface ram_copy_dma_16_8_if #(
    parameter int ADD_SIZE  = 4,
    parameter int RAM_WIDTH = 8
);
    logic                 start;
    logic [ADD_SIZE-1:0]  src_add;
    logic [ADD_SIZE-1:0]  dst_add;
    logic [ADD_SIZE:0]    len;
    logic                 busy;
    logic                 done;
    logic [ADD_SIZE:0]    count;
    logic                 ram_read;
    logic                 ram_write;
    logic [ADD_SIZE-1:0]  ram_rd_add;
    logic [ADD_SIZE-1:0]  ram_wr_add;
    logic [RAM_WIDTH-1:0] ram_d_in;
    logic [RAM_WIDTH-1:0] ram_d_out;
    logic [2:0]           fsm_state;

    modport master (
        output start, src_add, dst_add, len, ram_d_out,
        input  busy, done, count, ram_read, ram_write,
               ram_rd_add, ram_wr_add, ram_d_in, fsm_state
    );

    modport slave (
        input  start, src_add, dst_add, len, ram_d_out,
        output busy, done, count, ram_read, ram_write,
               ram_rd_add, ram_wr_add, ram_d_in, fsm_state
    );
endinterface

// File: rtl/ram_copy_dma_16_8.sv
// Word-by-word RAM-to-RAM copy engine: read, capture, write per word, forward order, addresses wrap.
// Every output is a flop; the FSM state is exported on fsm_state for observation.
module ram_copy_dma_16_8 #(
    parameter int ADD_SIZE  = 4,
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_copy_dma_16_8_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADD_SIZE:0] MAX_LEN = (ADD_SIZE + 1)'(RAM_DEPTH);

    state_t               state;
    logic [ADD_SIZE-1:0]  src_q;
    logic [ADD_SIZE-1:0]  dst_q;
    logic [ADD_SIZE:0]    len_q;
    logic [ADD_SIZE:0]    count_q;
    logic [RAM_WIDTH-1:0] data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_q;
    logic                 wr_q;
    logic [ADD_SIZE-1:0]  rd_add_q;
    logic [ADD_SIZE-1:0]  wr_add_q;

    logic [ADD_SIZE:0]    len_clamped;
    logic [ADD_SIZE:0]    count_next;
    logic [ADD_SIZE-1:0]  count_lo;
    logic [ADD_SIZE-1:0]  next_lo;

    // Address offsets use only the low bits of count, which gives the modulo-depth wrap for free.
    assign len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
    assign count_next  = count_q + (ADD_SIZE + 1)'(1);
    assign count_lo    = count_q[ADD_SIZE-1:0];
    assign next_lo     = count_next[ADD_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_add_q <= '0;
            wr_add_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q   <= bus.src_add;
                        dst_q   <= bus.dst_add;
                        len_q   <= len_clamped;
                        count_q <= '0;
                        if (len_clamped != '0) begin
                            state    <= RD;
                            busy_q   <= 1'b1;
                            rd_q     <= 1'b1;
                            rd_add_q <= bus.src_add;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    rd_q  <= 1'b0;
                    state <= CAP;
                end
                CAP: begin
                    // Read data arrives the cycle after ram_read; the register doubles as the write data.
                    data_q   <= bus.ram_d_out;
                    wr_q     <= 1'b1;
                    wr_add_q <= dst_q + count_lo;
                    state    <= WR;
                end
                WR: begin
                    wr_q    <= 1'b0;
                    count_q <= count_next;
                    if (count_next < len_q) begin
                        state    <= RD;
                        rd_q     <= 1'b1;
                        rd_add_q <= src_q + next_lo;
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.count      = count_q;
    assign bus.ram_read   = rd_q;
    assign bus.ram_write  = wr_q;
    assign bus.ram_rd_add = rd_add_q;
    assign bus.ram_wr_add = wr_add_q;
    assign bus.ram_d_in   = data_q;
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_ram_copy_dma_16_8.sv
// Bench for ram_copy_dma_16_8: a behavioural RAM, an array-level copy model and timing/count checks.
module tb_ram_copy_dma_16_8;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_copy_dma_16_8_if #(.ADD_SIZE(AW), .RAM_WIDTH(DW)) bus ();

    ram_copy_dma_16_8 #(.ADD_SIZE(AW), .RAM_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] load_img [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    logic          load_en = 1'b0;
    logic [DW-1:0] rd_q    = '0;

    int checks   = 0;
    int failures = 0;
    int n_rd = 0, n_wr = 0, n_both = 0, n_done = 0;

    assign bus.ram_d_out = rd_q;

    // Synchronous RAM; a reset aborts any write presented in the same cycle.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= load_img[i];
        end else if (bus.ram_write && !rst) begin
            mem[bus.ram_wr_add] <= bus.ram_d_in;
        end
        if (bus.ram_read) rd_q <= mem[bus.ram_rd_add];
        if (bus.ram_read) n_rd = n_rd + 1;
        if (bus.ram_write) n_wr = n_wr + 1;
        if (bus.ram_read && bus.ram_write) n_both = n_both + 1;
        if (bus.done) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_ram();
        for (int i = 0; i < DEPTH; i++) load_img[i] = ref_mem[i];
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic randomize_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    // Reference: a forward word-by-word copy over a circular array.
    task automatic model_copy(input int s, input int d, input int words);
        for (int i = 0; i < words; i++) ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];
    endtask

    task automatic run_copy(input string tag, input int s, input int d, input int l,
                            input bit poke_busy, input bit poke_done);
        int words, exp_lat, cyc, busy_bad, r0, w0, b0, d0;
        words   = (l > DEPTH) ? DEPTH : l;
        exp_lat = (words == 0) ? 1 : 3 * words + 1;
        model_copy(s, d, words);
        r0 = n_rd; w0 = n_wr; b0 = n_both; d0 = n_done;
        busy_bad = 0;
        bus.src_add = AW'(s);
        bus.dst_add = AW'(d);
        bus.len     = (AW + 1)'(l);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 200) begin
            if (!bus.busy) busy_bad++;
            if (poke_busy && cyc == 2) begin
                bus.start   = 1'b1;
                bus.src_add = AW'($urandom);
                bus.dst_add = AW'($urandom);
                bus.len     = (AW + 1)'($urandom_range(1, 31));
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_low_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_busy_during_copy"}, 32'(busy_bad), 32'd0);
        if (poke_done) begin
            bus.start   = 1'b1;
            bus.src_add = AW'($urandom);
            bus.dst_add = AW'($urandom);
            bus.len     = (AW + 1)'($urandom_range(1, 31));
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_count"}, 32'(bus.count), 32'(words));
        check({tag, "_reads"}, 32'(n_rd - r0), 32'(words));
        check({tag, "_writes"}, 32'(n_wr - w0), 32'(words));
        check({tag, "_rd_wr_overlap"}, 32'(n_both - b0), 32'd0);
        check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
        compare_mem(tag);
    endtask

    initial begin
        int d0, s, d;
        bus.start = 1'b0; bus.src_add = '0; bus.dst_add = '0; bus.len = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_ram_read", 32'(bus.ram_read), 32'd0);
        check("rst_ram_write", 32'(bus.ram_write), 32'd0);
        check("rst_rd_add", 32'(bus.ram_rd_add), 32'd0);
        check("rst_wr_add", 32'(bus.ram_wr_add), 32'd0);
        check("rst_d_in", 32'(bus.ram_d_in), 32'd0);

        randomize_ref();
        ref_mem[2] = 8'hA1; ref_mem[3] = 8'hB2; ref_mem[4] = 8'hC3;
        load_ram();
        run_copy("basic", 2, 9, 3, 1'b0, 1'b0);
        check("basic_word9", 32'(mem[9]), 32'hA1);
        check("basic_word11", 32'(mem[11]), 32'hC3);

        randomize_ref();
        ref_mem[14] = 8'h11; ref_mem[15] = 8'h22; ref_mem[0] = 8'h33;
        load_ram();
        run_copy("src_wrap", 14, 6, 3, 1'b0, 1'b0);
        check("src_wrap_word8", 32'(mem[8]), 32'h33);

        run_copy("len0", 5, 7, 0, 1'b0, 1'b0);

        randomize_ref();
        ref_mem[0] = 8'd1; ref_mem[1] = 8'd2; ref_mem[2] = 8'd3; ref_mem[3] = 8'd4;
        load_ram();
        run_copy("overlap", 0, 1, 3, 1'b0, 1'b0);
        check("overlap_word3", 32'(mem[3]), 32'd1);

        randomize_ref();
        load_ram();
        run_copy("ignore_start", 3, 10, 5, 1'b1, 1'b1);
        run_copy("len20_clamp", 4, 12, 20, 1'b0, 1'b0);

        // Abort in the second write cycle of a 4-word copy.
        randomize_ref();
        load_ram();
        d0 = n_done;
        bus.src_add = 4'd0; bus.dst_add = 4'd8; bus.len = 5'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_in_wr", 32'(bus.ram_write), 32'd1);
        check("abort_wr_add", 32'(bus.ram_wr_add), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_write", 32'(bus.ram_write), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        model_copy(0, 8, 1);
        compare_mem("abort");
        run_copy("after_abort", 1, 5, 4, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            randomize_ref();
            load_ram();
            s = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, DEPTH - 1);
            run_copy($sformatf("rand%0d", k), s, d, $urandom_range(0, 20),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_copy_dma_16_8.md
RAM_COPY_DMA_16_8 -- requirements
Module: ram_copy_dma_16_8

Interface
REQ-001 Parameter ADD_SIZE, default 4, SHALL set the RAM address width.
REQ-002 Parameter RAM_WIDTH, default 8, SHALL set the RAM data width.
REQ-003 Parameter RAM_DEPTH, default 16, SHALL set the number of RAM words (2**ADD_SIZE).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL request a copy; sampled only in IDLE.
REQ-007 src_add  input  ADD_SIZE  SHALL give the first source word address; sampled with start.
REQ-008 dst_add  input  ADD_SIZE  SHALL give the first destination word address; sampled with start.
REQ-009 len  input  ADD_SIZE+1  SHALL give the word count (0..16); sampled with start.
REQ-010 busy  output  1  SHALL be high while a copy is in progress.
REQ-011 done  output  1  SHALL pulse high for one cycle at copy completion.
REQ-012 count  output  ADD_SIZE+1  SHALL give the number of words written in the current or last copy.
REQ-013 ram_read  output  1  SHALL drive the RAM read enable.
REQ-014 ram_write  output  1  SHALL drive the RAM write enable.
REQ-015 ram_rd_add  output  ADD_SIZE  SHALL drive the RAM read address.
REQ-016 ram_wr_add  output  ADD_SIZE  SHALL drive the RAM write address.
REQ-017 ram_d_in  output  RAM_WIDTH  SHALL drive the RAM write data.
REQ-018 ram_d_out  input  RAM_WIDTH  SHALL carry RAM read data, valid the cycle after ram_read is high.

Function
REQ-019 FSM states SHALL be IDLE, RD, CAP, WR, DONE.
REQ-020 IDLE + start=1: latch src_add, dst_add, len (values >16 clamp to 16); count cleared to 0; next RD if len!=0, else DONE.
REQ-021 RD: ram_read=1, ram_rd_add=(src+count) mod 16; next CAP.
REQ-022 CAP: ram_d_out SHALL be registered into an internal data register; next WR.
REQ-023 WR: ram_write=1, ram_wr_add=(dst+count) mod 16, ram_d_in=data register; count increments at end of WR; next RD if incremented count<len, else DONE.
REQ-024 DONE: done=1, busy=0, one cycle; next IDLE.
REQ-025 busy SHALL be 1 exactly in RD, CAP, WR.
REQ-026 ram_read and ram_write SHALL never be high in the same cycle; both 0 in IDLE, CAP, DONE.
REQ-027 All outputs SHALL depend only on registered state (no combinational path from inputs).
REQ-028 Latency: start at edge T -> first RD cycle T+1; last WR cycle T+3*len; done cycle T+3*len+1; len=0 -> done cycle T+1 with no RAM access.
REQ-029 Address wrap-around SHALL be modulo 16 on both source and destination.
REQ-030 Words SHALL be copied in ascending order; overlapping ranges SHALL behave as a sequential forward copy.
REQ-031 start while busy or in DONE SHALL be ignored and SHALL NOT alter latched parameters.
REQ-032 ram_rd_add, ram_wr_add, ram_d_in SHALL hold their last values when not in use.
REQ-033 count SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE and clear busy, done, count, ram_read, ram_write, ram_rd_add, ram_wr_add, ram_d_in and the data register to 0.
REQ-035 rst SHALL take priority over start and over any in-progress copy; an interrupted copy SHALL NOT produce done.

Verification
REQ-036 Preload RAM[2..4]=8'hA1,8'hB2,8'hC3; start src=2, dst=9, len=3 -> RAM[9..11]=A1,B2,C3, done exactly 10 cycles after start edge, count=3.
REQ-037 Preload RAM[14],RAM[15],RAM[0]=8'h11,8'h22,8'h33; start src=14, dst=6, len=3 -> RAM[6..8]=11,22,33 (source wrap).
REQ-038 start len=0 -> done at next cycle, ram_read/ram_write never high, count=0.
REQ-039 Overlap: RAM[0..3]=1,2,3,4; start src=0, dst=1, len=3 -> RAM[1..3]=1,1,1.
REQ-040 Assert rst during second WR of a len=4 copy -> busy=0, done never pulses, only one destination word written; next start runs normally.
REQ-041 Pulse start with different parameters while busy -> ignored; original copy completes unchanged; len=20 -> exactly 16 words copied.
